// File: rtl/serial_add_driver.sv
// Parallel-to-serial driver for a bit-serial adder: shifts two operands out LSB-first
// as one contiguous vld/last frame and reassembles the returned sum bits into a word.
module serial_add_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_vld,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_last,
    input  logic             ser_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] sum_shift;
    logic [WIDTH-1:0] sum_next;
    logic             shifting;

    // Outputs are gated by rst so the adder sees vld=0 (and drops its carry)
    // in the very cycle reset is asserted, not one cycle later.
    always_comb begin
        shifting  = !rst && (state == SHIFT);
        in_ready  = !rst && (state == IDLE);
        out_valid = !rst && (state == RESULT);
        ser_vld   = shifting;
        ser_a     = shifting && a_shift[0];
        ser_b     = shifting && b_shift[0];
        ser_last  = shifting && (cnt == LAST_CNT);
        out_sum   = sum_shift;
        sum_next  = sum_shift >> 1;
        sum_next[WIDTH-1] = ser_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_shift   <= '0;
            b_shift   <= '0;
            sum_shift <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_shift <= in_a;
                    b_shift <= in_b;
                    cnt     <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    a_shift   <= a_shift >> 1;
                    b_shift   <= b_shift >> 1;
                    sum_shift <= sum_next;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_CNT) state <= RESULT;
                end
                RESULT: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_driver.sv
// Bench for serial_add_driver: a bit-serial adder model closes the loop, and a
// timeline model predicts every output each cycle from plain (a+b) mod 2^W arithmetic.
module tb_serial_add_driver;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         ser_vld, ser_a, ser_b, ser_last, ser_sum;

    logic         x_in_valid, x_in_ready, x_out_valid, x_out_ready;
    logic [0:0]   x_in_a, x_in_b, x_out_sum;
    logic         x_ser_vld, x_ser_a, x_ser_b, x_ser_last, x_ser_sum;

    serial_add_driver #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .ser_vld(ser_vld), .ser_a(ser_a), .ser_b(ser_b),
        .ser_last(ser_last), .ser_sum(ser_sum), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum));

    serial_add_driver #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .in_a(x_in_a), .in_b(x_in_b), .ser_vld(x_ser_vld), .ser_a(x_ser_a), .ser_b(x_ser_b),
        .ser_last(x_ser_last), .ser_sum(x_ser_sum), .out_valid(x_out_valid),
        .out_ready(x_out_ready), .out_sum(x_out_sum));

    // Serial adder partners: carry clears on vld=0, on reset and after the last bit.
    logic carry, x_carry;
    assign ser_sum   = ser_a ^ ser_b ^ carry;
    assign x_ser_sum = x_ser_a ^ x_ser_b ^ x_carry;
    always @(posedge clk) begin
        if (rst || !ser_vld || ser_last) carry <= 1'b0;
        else carry <= (ser_a & ser_b) | (carry & (ser_a ^ ser_b));
        if (rst || !x_ser_vld || x_ser_last) x_carry <= 1'b0;
        else x_carry <= (x_ser_a & x_ser_b) | (x_carry & (x_ser_a ^ x_ser_b));
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: phase 0 = waiting for operands, 1..W = driving bit phase-1,
    // W+1 = presenting the result. Expected sum comes from integer addition.
    int           phase = 0;
    int           cyc = 0;
    int           n_results = 0;
    logic [W-1:0] ma = '0, mb = '0;
    logic [W-1:0] exp_sum;
    int           acc_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) phase = 0;
        else if (phase == 0) begin
            if (in_valid) begin
                ma = in_a; mb = in_b; phase = 1;
                acc_cyc.push_back(cyc);
            end
        end else if (phase <= W) phase++;
        else if (out_ready) begin
            phase = 0;
            n_results++;
        end
    end

    bit model_on = 1'b0;
    always @(negedge clk) if (model_on) begin
        logic drv;
        drv     = !rst && phase >= 1 && phase <= W;
        exp_sum = W'((int'(ma) + int'(mb)) % (1 << W));
        chk("in_ready",  in_ready,  !rst && phase == 0);
        chk("ser_vld",   ser_vld,   drv);
        chk("ser_a",     ser_a,     drv ? ma[phase-1] : 1'b0);
        chk("ser_b",     ser_b,     drv ? mb[phase-1] : 1'b0);
        chk("ser_last",  ser_last,  drv && phase == W);
        chk("out_valid", out_valid, !rst && phase == W + 1);
        if (!rst && phase == W + 1) chk("out_sum", out_sum, exp_sum);
    end

    // Offer one operand pair, collect the serial frame and the result.
    // hold > 0: delay out_ready that many cycles; hold < 0: leave out_ready low.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                      output logic [W-1:0] res, output logic [W-1:0] bits, output int nvld);
        int n;
        bits = '0; nvld = 0; res = '0;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 50);
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid || n >= 50) break;
            if (ser_vld && nvld < W) bits[nvld] = ser_a;
            if (ser_vld) nvld++;
            n++;
        end
        if (!out_valid) chk("result_timeout", 0, 1);
        res = out_sum;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
        end
        if (hold >= 0) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [W-1:0] res, bits, ra, rb;
        int           nvld, n, nres;
        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; out_ready = 1;
        x_in_valid = 0; x_in_a = 0; x_in_b = 0; x_out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ser_vld", ser_vld, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_sum_w1", x_out_sum, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_on = 1'b1;

        // Directed frame: pins both serialisation order and the model's arithmetic
        op(8'h35, 8'h4A, 0, res, bits, nvld);
        chk("t1_sum", res, 8'h7F);
        chk("t1_bits", bits, 8'h35);
        chk("t1_nvld", nvld, 8);
        op(8'hFF, 8'h01, 0, res, bits, nvld); chk("t2_ff01", res, 8'h00);
        op(8'h80, 8'h80, 0, res, bits, nvld); chk("t2_8080", res, 8'h00);
        op(8'h00, 8'h00, 0, res, bits, nvld); chk("t2_0000", res, 8'h00);

        // Back-pressure with a new pair offered while the result waits
        op(8'hC3, 8'h5A, -1, res, bits, nvld);
        chk("t3_sum", res, 8'h1D);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34;
        repeat (5) begin
            @(negedge clk);
            chk("t3_stall_ready", in_ready, 0);
            chk("t3_stall_sum", out_sum, 8'h1D);
        end
        out_ready = 1'b1;
        op(8'h12, 8'h34, 0, res, bits, nvld);
        chk("t3_next", res, 8'h46);

        // Continuous in_valid: back-to-back operations at the minimum period
        acc_cyc.delete();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
            n = 0;
            do begin @(negedge clk); n++; end while (!in_ready && n < 50);
            if (!in_ready) chk("t4_timeout", 0, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (W + 3) @(negedge clk);
        chk("t4_ops", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("t4_period0", acc_cyc[1] - acc_cyc[0], W + 2);
            chk("t4_period1", acc_cyc[2] - acc_cyc[1], W + 2);
        end

        // Reset in the middle of a frame
        nres = n_results;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 50);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_vld_in_rst", ser_vld, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            chk("t5_no_result", out_valid, 0);
        end
        chk("t5_result_count", n_results, nres);
        op(8'h0F, 8'h01, 0, res, bits, nvld);
        chk("t5_after", res, 8'h10);

        // Randomised operations with random consumer delay
        for (int k = 0; k < 20; k++) begin
            ra = W'($urandom); rb = W'($urandom);
            op(ra, rb, int'($urandom_range(0, 3)), res, bits, nvld);
            chk("rand_sum", res, W'(ra + rb));
            chk("rand_bits", bits, ra);
        end

        // Single-bit instance
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            x_in_valid = 1'b1; x_in_a = 1'b1; x_in_b = (k == 0);
            n = 0;
            do begin @(negedge clk); n++; end while (!x_in_ready && n < 50);
            @(posedge clk); #1;
            x_in_valid = 1'b0;
            @(negedge clk);
            chk("w1_vld", x_ser_vld, 1);
            chk("w1_last", x_ser_last, 1);
            @(negedge clk);
            chk("w1_vld_off", x_ser_vld, 0);
            chk("w1_out_valid", x_out_valid, 1);
            chk("w1_sum", x_out_sum, (k == 0) ? 1'b0 : 1'b1);
        end
        @(posedge clk); #1;

        model_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
